// File: rtl/frame_sequencer.sv
// frame_sequencer: frame tick, UPDATE start/done handshake and raster scan feeding the VGA adapter.
// Define FRAME_SEQ_OVERRUN_CNT_EN to add o_overrun_cnt, a saturating count of dropped ticks.
module frame_sequencer #(
  parameter int FRAME_CYCLES   = 833333,
  parameter int X_MAX          = 159,
  parameter int Y_MAX          = 119,
  parameter int UPDATE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_enable,
  output logic       o_frame_tick,
  output logic       o_update_start,
  input  logic       i_update_done,
  output logic [7:0] o_scan_x,
  output logic [7:0] o_scan_y,
  output logic       o_scan_active,
  input  logic [2:0] i_pix_color,
  output logic [7:0] o_vga_x,
  output logic [6:0] o_vga_y,
  output logic [2:0] o_vga_color,
  output logic       o_vga_plot,
  output logic [1:0] o_phase,
  output logic       o_overrun,
  output logic       o_upd_timeout
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0] o_overrun_cnt
`endif
);
  localparam int FW = $clog2(FRAME_CYCLES + 1);
  localparam int WW = $clog2(UPDATE_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, UPDATE, SCAN, DRAIN} state_t;
  state_t          r_state;
  logic [FW-1:0]   r_fcnt;
  logic [WW-1:0]   r_wait;
  logic            w_done;
  logic            w_tmo;
  assign o_frame_tick = r_fcnt == FW'(FRAME_CYCLES - 1);
  // done is only honoured from the second UPDATE cycle, so a level held high still costs one cycle
  assign w_done       = r_wait != '0 && i_update_done;
  assign w_tmo        = r_wait == WW'(UPDATE_TIMEOUT - 1);
  assign o_vga_color  = i_pix_color;
  assign o_phase      = r_state;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_fcnt         <= '0;
      r_wait         <= '0;
      o_update_start <= 1'b0;
      o_scan_x       <= '0;
      o_scan_y       <= '0;
      o_scan_active  <= 1'b0;
      o_vga_x        <= '0;
      o_vga_y        <= '0;
      o_vga_plot     <= 1'b0;
      o_overrun      <= 1'b0;
      o_upd_timeout  <= 1'b0;
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
      o_overrun_cnt  <= '0;
`endif
    end else begin
      r_fcnt         <= o_frame_tick ? '0 : r_fcnt + 1'b1;
      o_vga_x        <= o_scan_x;
      o_vga_y        <= o_scan_y[6:0];
      o_vga_plot     <= o_scan_active;
      o_update_start <= 1'b0;
      if (o_frame_tick && r_state != IDLE) begin
        o_overrun <= 1'b1;
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
        if (o_overrun_cnt != 8'hFF) o_overrun_cnt <= o_overrun_cnt + 8'd1;
`endif
      end
      case (r_state)
        IDLE: if (o_frame_tick && i_enable) begin
          r_state        <= UPDATE;
          o_update_start <= 1'b1;
          r_wait         <= '0;
        end
        UPDATE: begin
          r_wait <= r_wait + 1'b1;
          if (w_done || w_tmo) begin
            r_state       <= SCAN;
            o_scan_active <= 1'b1;
            if (!w_done) o_upd_timeout <= 1'b1;
          end
        end
        SCAN: if (o_scan_x == 8'(X_MAX)) begin
          o_scan_x <= '0;
          if (o_scan_y == 8'(Y_MAX)) begin
            o_scan_y      <= '0;
            o_scan_active <= 1'b0;
            r_state       <= DRAIN;
          end else o_scan_y <= o_scan_y + 8'd1;
        end else o_scan_x <= o_scan_x + 8'd1;
        DRAIN: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: frame_sequencer with a 4x3 scan, two frame periods (40 and 10 cycles).
module tb_frame_sequencer;
  logic clk = 0, resetn = 0, enable = 0, done = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= !resetn ? 0 : cyc + 1;
  logic a_tick, a_start, a_act, a_plot, a_ovr, a_tmo;
  logic [7:0] a_x, a_y, a_vx;
  logic [6:0] a_vy;
  logic [2:0] a_vc, a_pix;
  logic [1:0] a_phase;
  logic b_tick, b_start, b_act, b_plot, b_ovr, b_tmo;
  logic [7:0] b_x, b_y, b_vx;
  logic [6:0] b_vy;
  logic [2:0] b_vc;
  logic [2:0] b_pix = 3'd5;
  logic [1:0] b_phase;
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
  logic [7:0] a_cnt, b_cnt;
`endif
  // renderer stand-in: colour for the coordinates of the previous cycle
  always @(posedge clk) a_pix <= 3'(a_x + a_y);
  frame_sequencer #(.FRAME_CYCLES(40), .X_MAX(3), .Y_MAX(2), .UPDATE_TIMEOUT(5)) dut_a (
    .clk(clk), .resetn(resetn), .i_enable(enable), .o_frame_tick(a_tick), .o_update_start(a_start),
    .i_update_done(done), .o_scan_x(a_x), .o_scan_y(a_y), .o_scan_active(a_act), .i_pix_color(a_pix),
    .o_vga_x(a_vx), .o_vga_y(a_vy), .o_vga_color(a_vc), .o_vga_plot(a_plot), .o_phase(a_phase),
    .o_overrun(a_ovr), .o_upd_timeout(a_tmo)
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
    , .o_overrun_cnt(a_cnt)
`endif
  );
  frame_sequencer #(.FRAME_CYCLES(10), .X_MAX(3), .Y_MAX(2), .UPDATE_TIMEOUT(5)) dut_b (
    .clk(clk), .resetn(resetn), .i_enable(enable), .o_frame_tick(b_tick), .o_update_start(b_start),
    .i_update_done(done), .o_scan_x(b_x), .o_scan_y(b_y), .o_scan_active(b_act), .i_pix_color(b_pix),
    .o_vga_x(b_vx), .o_vga_y(b_vy), .o_vga_color(b_vc), .o_vga_plot(b_plot), .o_phase(b_phase),
    .o_overrun(b_ovr), .o_upd_timeout(b_tmo)
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
    , .o_overrun_cnt(b_cnt)
`endif
  );
  int total = 0, bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask
  task automatic do_reset(input logic en, input logic dn);
    @(negedge clk);
    resetn = 0;
    enable = en;
    done = dn;
    @(negedge clk);
    resetn = 1;
  endtask
  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) chk("wait_budget", cyc, n);
  endtask
  typedef struct {
    logic en;
    logic dn;
    int c;
    logic [6:0] e;
  } vec_t;
  vec_t vt[$];
  task automatic addv(input logic en, dn, input int c, input logic [1:0] ph,
                      input logic tk, st, ac, pl, to);
    vec_t v;
    v.en = en; v.dn = dn; v.c = c; v.e = {ph, tk, st, ac, pl, to};
    vt.push_back(v);
  endtask
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } pix_t;
  pix_t qs[$], qv[$];
  initial begin
    pix_t p;
    int n_act, n_plot, f_act, f_plot, n_start, drops;
    // en dn cyc | phase tick start active plot timeout
    addv(1, 1, 0, 0, 0, 0, 0, 0, 0);
    addv(1, 1, 39, 0, 1, 0, 0, 0, 0);
    addv(1, 1, 40, 1, 0, 1, 0, 0, 0);
    addv(1, 1, 41, 1, 0, 0, 0, 0, 0);
    addv(1, 1, 42, 2, 0, 0, 1, 0, 0);
    addv(1, 1, 43, 2, 0, 0, 1, 1, 0);
    addv(1, 1, 53, 2, 0, 0, 1, 1, 0);
    addv(1, 1, 54, 3, 0, 0, 0, 1, 0);
    addv(1, 1, 55, 0, 0, 0, 0, 0, 0);
    addv(0, 1, 39, 0, 1, 0, 0, 0, 0);
    addv(0, 1, 40, 0, 0, 0, 0, 0, 0);
    addv(0, 1, 46, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 44, 1, 0, 0, 0, 0, 0);
    addv(1, 0, 45, 2, 0, 0, 1, 0, 1);
    addv(1, 0, 57, 3, 0, 0, 0, 1, 1);
    addv(1, 0, 79, 0, 1, 0, 0, 0, 1);
    addv(1, 0, 80, 1, 0, 1, 0, 0, 1);
    foreach (vt[i]) begin
      do_reset(vt[i].en, vt[i].dn);
      wait_cyc(vt[i].c);
      chk($sformatf("vec%0d_ph_tk_st_ac_pl_to", i),
          int'({a_phase, a_tick, a_start, a_act, a_plot, a_tmo}), int'(vt[i].e));
    end
    do_reset(1, 1);
    chk("reset_scan_xy", int'({a_x, a_y, a_vx, a_vy}), 0);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) begin
        p.x = 8'(x);
        p.y = 8'(y);
        qs.push_back(p);
        qv.push_back(p);
      end
    n_act = 0; n_plot = 0; f_act = -1; f_plot = -1;
    while (cyc <= 60) begin
      if (a_act) begin
        if (f_act < 0) f_act = cyc;
        n_act++;
        if (qs.size() == 0) chk("scan_extra", n_act, 12);
        else begin
          p = qs.pop_front();
          chk("scan_xy", int'({a_x, a_y}), int'({p.x, p.y}));
        end
      end
      if (a_plot) begin
        if (f_plot < 0) f_plot = cyc;
        n_plot++;
        if (qv.size() == 0) chk("vga_extra", n_plot, 12);
        else begin
          p = qv.pop_front();
          chk("vga_xy", int'({a_vx, a_vy}), int'({p.x, p.y[6:0]}));
          chk("vga_color", int'(a_vc), int'(3'(p.x + p.y)));
        end
      end
      @(negedge clk);
    end
    chk("n_scan_active", n_act, 12);
    chk("n_vga_plot", n_plot, 12);
    chk("first_active_cyc", f_act, 42);
    chk("first_plot_cyc", f_plot, 43);
    do_reset(1, 1);
    n_act = 0; n_start = 0;
    while (cyc <= 30) begin
      if (cyc == 19) chk("ovr_tick_in_scan", int'({b_tick, b_phase, b_ovr}), int'({1'b1, 2'd2, 1'b0}));
      if (cyc == 20) chk("overrun_set", int'(b_ovr), 1);
      if (cyc >= 11 && cyc <= 29 && b_start) n_start++;
      if (cyc >= 12 && cyc <= 25 && b_act) n_act++;
      if (cyc == 30) chk("next_update_start", int'(b_start), 1);
      @(negedge clk);
    end
    chk("ovr_no_extra_start", n_start, 0);
    chk("ovr_frame_pixels", n_act, 12);
    do_reset(1, 0);
    wait_cyc(21);
    chk("pre_rst_state", int'({b_x, b_y, b_plot, b_ovr, b_tmo}), int'({8'd2, 8'd1, 3'b111}));
    resetn = 0;
    @(negedge clk);
    chk("mid_rst_state", int'({b_phase, b_x, b_y, b_act, b_plot, b_ovr, b_tmo}), 0);
    resetn = 1;
`ifdef FRAME_SEQ_OVERRUN_CNT_EN
    do_reset(1, 1);
    drops = 0;
    for (int g = 0; g < 7000 && drops < 300; g++) begin
      chk("overrun_cnt", int'(b_cnt), drops > 255 ? 255 : drops);
      if (b_tick && b_phase != 2'd0) drops++;
      @(negedge clk);
    end
    chk("drops_reached", drops, 300);
    chk("overrun_cnt_sat", int'(b_cnt), 255);
    chk("overrun_flag", int'(b_ovr), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
